// File: rtl/input_sweep_sequencer.sv
// Stimulus-and-capture sequencer for final_circuit.
// Drives EN and walks {a,b,c,d} through 0000..1111, holding each vector for
// SETTLE_CYCLES before sampling f. Builds the observed truth table, compares
// it against a latched expected table and reports done/pass/mismatch count.
//
// state  | meaning
// IDLE   | waiting for start after reset
// DRIVE  | current vector applied, settle counter running
// SAMPLE | one cycle: capture f for the current vector
// DONE   | results held until the next start
//
// Every output is a register fed from the current state and datapath, so all
// outputs trail the internal state by one clock. This lets a held-high start
// restart straight out of DONE while done/result/pass remain visible for one
// cycle.
module input_sweep_sequencer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] expected,
  input  logic        f,
  output logic        en,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] result,
  output logic [4:0]  mismatch_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        idx;
  logic [CNT_W-1:0]  cnt;
  logic [15:0]       exp_lat;
  logic [15:0]       res_int;
  logic [4:0]        mm_int;
  logic [3:0]        vec_q;
  logic              sweeping;

  assign sweeping     = (state == DRIVE) || (state == SAMPLE);
  assign {a, b, c, d} = vec_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; start is only honoured from IDLE or DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = DRIVE;
      end
      DRIVE: begin
        if (cnt == CNT_LAST) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        state_nxt = (idx == 4'hF) ? DONE : DRIVE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sweep datapath: vector index, settle timer, capture and mismatch tally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      cnt     <= '0;
      exp_lat <= '0;
      res_int <= '0;
      mm_int  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            exp_lat <= expected;
            res_int <= '0;
            mm_int  <= '0;
            idx     <= '0;
            cnt     <= '0;
          end
        end
        DRIVE: begin
          if (cnt != CNT_LAST) cnt <= cnt + CNT_W'(1);
        end
        SAMPLE: begin
          res_int[idx] <= f;
          if (f != exp_lat[idx]) mm_int <= mm_int + 5'd1;
          if (idx != 4'hF) begin
            idx <= idx + 4'd1;
            cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs; pass uses the tally already including the last sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en           <= 1'b0;
      vec_q        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      result       <= '0;
      mismatch_cnt <= '0;
    end else begin
      en           <= sweeping;
      vec_q        <= sweeping ? idx : 4'h0;
      busy         <= sweeping;
      done         <= (state == DONE);
      pass         <= (state == DONE) && (mm_int == 5'd0);
      result       <= res_int;
      mismatch_cnt <= mm_int;
    end
  end

endmodule

// File: tb/tb_input_sweep_sequencer.sv
// Bench for input_sweep_sequencer: a truth-table model of final_circuit drives f,
// expected sweep outcomes go into a scoreboard and a monitor checks them.
module tb_input_sweep_sequencer;

  localparam int S = 4;
  localparam int P = S + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] expected = '0;
  logic [15:0] truth = '0;
  logic        f;
  logic        en, a, b, c, d, busy, done, pass;
  logic [15:0] result;
  logic [4:0]  mismatch_cnt;
  logic [3:0]  vec;

  logic        start1 = 1'b0;
  logic [15:0] expected1 = '0;
  logic [15:0] truth1 = '0;
  logic        f1;
  logic        en1, a1, b1, c1, d1, busy1, done1, pass1;
  logic [15:0] result1;
  logic [4:0]  mismatch_cnt1;
  logic [3:0]  vec1;

  input_sweep_sequencer #(.SETTLE_CYCLES(S), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .f(f),
    .en(en), .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done),
    .pass(pass), .result(result), .mismatch_cnt(mismatch_cnt)
  );

  input_sweep_sequencer #(.SETTLE_CYCLES(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .expected(expected1), .f(f1),
    .en(en1), .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
    .pass(pass1), .result(result1), .mismatch_cnt(mismatch_cnt1)
  );

  always #5 clk = ~clk;

  assign vec  = {a, b, c, d};
  assign vec1 = {a1, b1, c1, d1};
  // Circuit-under-test model: f is the truth table entry for the applied vector.
  assign f    = en  ? truth[vec]   : 1'b0;
  assign f1   = en1 ? truth1[vec1] : 1'b0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [15:0] res;
    logic [4:0]  mm;
    logic        pss;
    int          done_edge;
  } exp_t;

  exp_t sb[$];

  int         done_rises = 0;
  logic       done_prev = 1'b0;
  logic       en_prev = 1'b0;
  logic [3:0] vec_prev = '0;
  int         exp_vec = 0;
  int         sw_start = 0;

  function automatic exp_t model(input logic [15:0] tr, input logic [15:0] ex, input int s_edge);
    exp_t e;
    e.res       = tr;
    e.mm        = 5'($countones(tr ^ ex));
    e.pss       = (tr == ex);
    e.done_edge = s_edge + 16 * P + 1;
    return e;
  endfunction

  // Monitor: pops the scoreboard on each done rise, checks vector order and timing.
  always @(posedge clk) begin
    #2;
    if (done && !done_prev) begin
      done_rises++;
      if (sb.size() == 0) begin
        chk("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", {16'd0, result}, {16'd0, e.res});
        chk("mismatch_cnt", {27'd0, mismatch_cnt}, {27'd0, e.mm});
        chk("pass", {31'd0, pass}, {31'd0, e.pss});
        chk("done_edge", cyc, e.done_edge);
      end
    end
    if (en && (!en_prev || vec != vec_prev)) begin
      chk("vec_order", {28'd0, vec}, exp_vec);
      chk("vec_edge", cyc, sw_start + 1 + exp_vec * P);
      exp_vec++;
    end
    done_prev = done;
    en_prev   = en;
    vec_prev  = vec;
  end

  task automatic start_sweep(input logic [15:0] ex, input logic [15:0] tr);
    @(negedge clk);
    expected = ex;
    truth    = tr;
    start    = 1'b1;
    sw_start = cyc + 1;
    exp_vec  = 0;
    sb.push_back(model(tr, ex, sw_start));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    d0 = done_rises;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_rises != d0) break;
    end
    if (done_rises == d0) chk("done_timeout", done_rises, d0 + 1);
  endtask

  task automatic wait_vec(input logic [3:0] v, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (en && vec == v) break;
    end
    if (!(en && vec == v)) chk("wait_vec", {28'd0, vec}, {28'd0, v});
  endtask

  initial begin
    int s0;
    int d0;
    logic [15:0] ex;
    logic [15:0] tr;

    // Reset values and idle behaviour.
    #3;
    chk("reset_outputs", {3'd0, en, vec, busy, done, pass, result, mismatch_cnt}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_outputs", {28'd0, en, busy, done, vec1[0]}, 32'd0);
    chk("idle_vec", {28'd0, vec}, 32'd0);

    // Passing sweep, stuck-at-0 sweep, single inverted vector.
    start_sweep(16'hA5C3, 16'hA5C3);
    wait_done(120);
    start_sweep(16'hFFFF, 16'h0000);
    wait_done(120);
    start_sweep(16'hA5C3, 16'hA1C3);
    wait_done(120);

    // start during vector 5 is ignored; expected changes have no effect.
    start_sweep(16'h5AA5, 16'h5AA5);
    wait_vec(4'd5, 60);
    start    = 1'b1;
    expected = 16'h1234;
    @(negedge clk);
    start = 1'b0;
    wait_done(120);

    // Restart from DONE clears results on the following edge.
    tr = 16'($urandom);
    start_sweep(16'h0000, tr);
    @(negedge clk);
    chk("restart_result", {16'd0, result}, 32'd0);
    chk("restart_mm", {27'd0, mismatch_cnt}, 32'd0);
    chk("restart_done", {31'd0, done}, 32'd0);
    chk("restart_vec", {27'd0, en, vec}, 32'h10);
    wait_done(120);

    // Held-high start restarts on entering DONE; done lasts one cycle.
    @(negedge clk);
    expected = 16'hC33C;
    truth    = 16'hC13C;
    start    = 1'b1;
    sw_start = cyc + 1;
    exp_vec  = 0;
    s0       = sw_start;
    sb.push_back(model(truth, expected, sw_start));
    wait_done(120);
    chk("held_start_done_edge", cyc, s0 + 16 * P + 1);
    sw_start = s0 + 16 * P + 1;
    exp_vec  = 0;
    sb.push_back(model(truth, expected, sw_start));
    start = 1'b0;
    @(negedge clk);
    chk("held_done_pulse", {30'd0, done, busy}, 32'd1);
    wait_done(120);

    // Randomized sweeps.
    repeat (4) begin
      ex = 16'($urandom);
      tr = ($urandom_range(0, 1) == 0) ? ex : (ex ^ 16'($urandom));
      start_sweep(ex, tr);
      wait_done(120);
    end

    // Reset during vector 7: asynchronous clear and no done afterwards.
    start_sweep(16'hA5C3, 16'($urandom));
    wait_vec(4'd7, 60);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {3'd0, en, vec, busy, done, pass, result, mismatch_cnt}, 32'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    d0 = done_rises;
    repeat (100) @(negedge clk);
    chk("midreset_no_done", done_rises, d0);
    chk("midreset_idle", {28'd0, en, busy, done, pass}, 32'd0);

    // Short settle instance: each vector held 2 cycles, done after edge 33.
    begin
      int s1;
      int v1;
      logic       en1_p;
      logic [3:0] vec1_p;
      logic       seen;
      v1     = 0;
      en1_p  = 1'b0;
      vec1_p = '0;
      seen   = 1'b0;
      @(negedge clk);
      expected1 = 16'h3C96;
      truth1    = 16'h3C16;
      start1    = 1'b1;
      s1        = cyc + 1;
      @(negedge clk);
      start1 = 1'b0;
      for (int i = 0; i < 60; i++) begin
        if (en1 && (!en1_p || vec1 != vec1_p)) begin
          chk("s1_vec_order", {28'd0, vec1}, v1);
          chk("s1_vec_edge", cyc, s1 + 1 + 2 * v1);
          v1++;
        end
        if (done1) begin
          chk("s1_done_edge", cyc, s1 + 33);
          chk("s1_result", {16'd0, result1}, {16'd0, truth1});
          chk("s1_mm", {27'd0, mismatch_cnt1}, 5'($countones(truth1 ^ expected1)));
          chk("s1_pass", {31'd0, pass1}, {31'd0, truth1 == expected1});
          seen = 1'b1;
          break;
        end
        en1_p  = en1;
        vec1_p = vec1;
        @(negedge clk);
      end
      if (!seen) chk("s1_done_timeout", {31'd0, done1}, 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
